// File: rtl/axis_lane_dispatch.sv
// AXI-stream frame dispatcher: splits each raster row into N column
// stripes, one per upsampler lane, each behind a small lane FIFO.
module axis_lane_dispatch #(
  parameter int AXISIN_DATA_WIDTH = 24,
  parameter int N_PARALLEL        = 4,
  parameter int SRC_IMG_WIDTH     = 960,
  parameter int SRC_IMG_HEIGHT    = 540,
  parameter int LANE_FIFO_DEPTH   = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    crf_ac_UPSTART,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  input  logic [AXISIN_DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic                                    s_axis_tlast,
  input  logic                                    s_axis_tuser,
  output logic [N_PARALLEL-1:0]                   ac_upsp_rvalid,
  output logic [N_PARALLEL*AXISIN_DATA_WIDTH-1:0] ac_upsp_rdata,
  output logic [N_PARALLEL-1:0]                   ac_upsp_rlast,
  input  logic [N_PARALLEL-1:0]                   upsp_ac_rready,
  output logic                                    ac_crf_processing,
  output logic                                    ac_crf_done,
  output logic                                    ac_crf_err_sof,
  output logic                                    ac_crf_err_tlast
);

  localparam int W      = AXISIN_DATA_WIDTH;
  localparam int STRIPE = SRC_IMG_WIDTH / N_PARALLEL;
  localparam int CW     = (SRC_IMG_WIDTH  > 1) ? $clog2(SRC_IMG_WIDTH)  : 1;
  localparam int RW     = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;
  localparam int SW     = (STRIPE > 1) ? $clog2(STRIPE) : 1;
  localparam int LW     = (N_PARALLEL > 1) ? $clog2(N_PARALLEL) : 1;
  localparam int AW     = $clog2(LANE_FIFO_DEPTH);
  localparam int EW     = W + 1;

  if (SRC_IMG_WIDTH % N_PARALLEL != 0) begin : g_bad_width
    $error("SRC_IMG_WIDTH must be divisible by N_PARALLEL");
  end
  if (LANE_FIFO_DEPTH < 2 || (1 << AW) != LANE_FIFO_DEPTH) begin : g_bad_depth
    $error("LANE_FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [2:0] {
    IDLE, WAIT_SOF, RUN, DRAIN, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [SW-1:0]   stripe_q, stripe_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic            err_sof_q, err_sof_d;
  logic            err_tlast_q, err_tlast_d;
  logic            done_q, done_d;
  logic            proc_q, proc_d;

  logic                  push;
  logic                  col_last, row_last, stripe_last, frame_last;
  logic [N_PARALLEL-1:0] full, empty_nx;

  assign col_last    = col_q == CW'(SRC_IMG_WIDTH - 1);
  assign row_last    = row_q == RW'(SRC_IMG_HEIGHT - 1);
  assign stripe_last = stripe_q == SW'(STRIPE - 1);
  assign frame_last  = col_last && row_last;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    stripe_d      = stripe_q;
    lane_d        = lane_q;
    err_sof_d     = err_sof_q;
    err_tlast_d   = err_tlast_q;
    s_axis_tready = 1'b0;
    push          = 1'b0;
    unique case (state_q)
      IDLE: begin
        col_d    = '0;
        row_d    = '0;
        stripe_d = '0;
        lane_d   = '0;
        if (crf_ac_UPSTART) begin
          state_d     = WAIT_SOF;
          err_sof_d   = 1'b0;
          err_tlast_d = 1'b0;
        end
      end
      WAIT_SOF: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tuser) begin
          push    = 1'b1;
          state_d = frame_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        s_axis_tready = !full[lane_q];
        if (s_axis_tvalid && s_axis_tready) begin
          push = 1'b1;
          if (s_axis_tlast != col_last) err_tlast_d = 1'b1;
          if (s_axis_tuser) err_sof_d = 1'b1;
          if (frame_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (&empty_nx) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Stripe counter and lane index wrap together, so no divider is needed.
    if (push) begin
      if (col_last) begin
        col_d    = '0;
        stripe_d = '0;
        lane_d   = '0;
        row_d    = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
        if (stripe_last) begin
          stripe_d = '0;
          lane_d   = lane_q + LW'(1);
        end else begin
          stripe_d = stripe_q + SW'(1);
        end
      end
    end
    done_d = state_d == DONE;
    proc_d = state_d == WAIT_SOF || state_d == RUN || state_d == DRAIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      stripe_q    <= '0;
      lane_q      <= '0;
      err_sof_q   <= 1'b0;
      err_tlast_q <= 1'b0;
      done_q      <= 1'b0;
      proc_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      stripe_q    <= stripe_d;
      lane_q      <= lane_d;
      err_sof_q   <= err_sof_d;
      err_tlast_q <= err_tlast_d;
      done_q      <= done_d;
      proc_q      <= proc_d;
    end
  end

  assign ac_crf_processing = proc_q;
  assign ac_crf_done       = done_q;
  assign ac_crf_err_sof    = err_sof_q;
  assign ac_crf_err_tlast  = err_tlast_q;

  for (genvar i = 0; i < N_PARALLEL; i++) begin : g_lane
    logic [EW-1:0] mem_q [LANE_FIFO_DEPTH];
    logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
    logic          lpush, lpop, empty;
    logic [EW-1:0] head;

    assign empty = wp_q == rp_q;
    assign full[i] = (wp_q[AW] != rp_q[AW]) &&
                     (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign lpush = push && (lane_q == LW'(i));
    assign lpop  = !empty && upsp_ac_rready[i];

    always_comb begin
      wp_d = lpush ? wp_q + (AW+1)'(1) : wp_q;
      rp_d = lpop  ? rp_q + (AW+1)'(1) : rp_q;
    end

    assign empty_nx[i] = wp_d == rp_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        wp_q <= wp_d;
        rp_q <= rp_d;
      end
    end

    always_ff @(posedge clk) begin
      if (lpush) mem_q[wp_q[AW-1:0]] <= {stripe_last, s_axis_tdata};
    end

    assign head                   = mem_q[rp_q[AW-1:0]];
    assign ac_upsp_rvalid[i]      = !empty;
    assign ac_upsp_rlast[i]       = head[W];
    assign ac_upsp_rdata[i*W +: W] = head[W-1:0];
  end

endmodule
